game_link_tx: RTL

//  Transmit side of the board-to-board game link. Turns local game events (enter, turn done,
//  HP change, heartbeat) into fixed-length byte packets and drives them onto the UART TX byte

---
 rtl/game_link_pkg.sv | 36 +++
 rtl/link_heartbeat_timer.sv | 37 +++
 rtl/game_link_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/game_link_pkg.sv
// rtl/game_link_pkg.sv - shared constants and types for the game link TX/RX pair
// Purpose: sync byte, packet type codes, transmit FSM state type and packet length.
// Packet length and the CHK state follow GAME_LINK_CHECKSUM_EN (defined: 5 bytes with
// trailing XOR checksum; undefined: 4 bytes). Both link ends must be built the same way.
package game_link_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] TYPE_ENTER = 8'h01;
  localparam logic [7:0] TYPE_TURN  = 8'h02;
  localparam logic [7:0] TYPE_HP    = 8'h03;
  localparam logic [7:0] TYPE_HB    = 8'h04;

`ifdef GAME_LINK_CHECKSUM_EN
  localparam int PKT_LEN = 5;
`else
  localparam int PKT_LEN = 4;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_TYPE,
    ST_PHI,
    ST_PLO
`ifdef GAME_LINK_CHECKSUM_EN
    ,
    ST_CHK
`endif
  } tx_state_t;

  // Checksum covers the type byte and both payload bytes, not SYNC.
  function automatic logic [7:0] pkt_chk(input logic [7:0] pkt_type, input logic [15:0] pay);
    return pkt_type ^ pay[15:8] ^ pay[7:0];
  endfunction

endpackage

// File: rtl/link_heartbeat_timer.sv
// rtl/link_heartbeat_timer.sv - idle-time counter that requests heartbeat packets
// Purpose: counts enabled cycles up to HEARTBEAT_CYCLES-1 and holds there with pending high
// until cleared. HEARTBEAT_CYCLES=0 disables it (pending never rises).
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   en        count this cycle (transmitter idle, nothing else pending)
//   clear     restart the count (a packet was loaded)
//   pending   heartbeat due
module link_heartbeat_timer #(
  parameter int unsigned HEARTBEAT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic pending
);

  localparam bit          ENABLED = (HEARTBEAT_CYCLES != 0);
  localparam int unsigned LIMIT   = ENABLED ? HEARTBEAT_CYCLES - 1 : 0;
  localparam int          CW      = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count;

  // Stops at LIMIT so pending stays asserted until the heartbeat is loaded.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (ENABLED && en && (count != LIMIT_C)) begin
      count <= count + 1'b1;
    end
  end

  assign pending = ENABLED && (count == LIMIT_C);

endmodule

// File: rtl/game_link_tx.sv
// rtl/game_link_tx.sv - game link transmitter: local events to fixed-length byte packets
// Purpose: latches enter/turn pulses, HP changes and heartbeat requests, then sends one
// packet per event as SYNC, TYPE, PAY_HI, PAY_LO[, CHK] over a valid/ready byte interface.
// Priority ENTER > TURN > HP > HB. GAME_LINK_CHECKSUM_EN adds the trailing CHK byte.
// Ports:
//   clk, rst             clock, synchronous active-high reset (abandons packet in flight)
//   enter_pressed_local  1-cycle pulse, local Enter press
//   turn_done_local      1-cycle pulse, local turn finished
//   hp_local             current local HP level
//   state_game_fsm       game FSM state, carried in the ENTER payload
//   tx_ready             byte sink accepts tx_data this cycle
//   tx_data, tx_valid    byte being offered
//   busy                 packet in progress
//   pkt_sent             pulse the cycle after the last byte of a packet transfers
module game_link_tx
  import game_link_pkg::*;
#(
  parameter int unsigned HEARTBEAT_CYCLES = 50_000_000,
  parameter int          HP_W             = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enter_pressed_local,
  input  logic            turn_done_local,
  input  logic [HP_W-1:0] hp_local,
  input  logic [2:0]      state_game_fsm,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  output logic            busy,
  output logic            pkt_sent
);

  tx_state_t state, state_next;

  logic            enter_pend, turn_pend, hp_pend, hb_pend;
  logic [HP_W-1:0] hp_shadow;
  logic [7:0]      type_q;
  logic [15:0]     pay_q;

  logic        load, take_enter, take_turn, take_hp;
  logic [7:0]  load_type;
  logic [15:0] load_pay;
  logic        last_byte;

  assign hp_pend = (hp_local != hp_shadow);

  link_heartbeat_timer #(
    .HEARTBEAT_CYCLES(HEARTBEAT_CYCLES)
  ) u_hb_timer (
    .clk    (clk),
    .rst    (rst),
    .en     ((state == ST_IDLE) && !enter_pend && !turn_pend && !hp_pend),
    .clear  (load),
    .pending(hb_pend)
  );

  // Packet selection in IDLE; the payload is snapshotted from the inputs at this point.
  always_comb begin
    load       = 1'b0;
    take_enter = 1'b0;
    take_turn  = 1'b0;
    take_hp    = 1'b0;
    load_type  = '0;
    load_pay   = '0;
    if (state == ST_IDLE) begin
      if (enter_pend) begin
        load       = 1'b1;
        take_enter = 1'b1;
        load_type  = TYPE_ENTER;
        load_pay   = {13'b0, state_game_fsm};
      end else if (turn_pend) begin
        load      = 1'b1;
        take_turn = 1'b1;
        load_type = TYPE_TURN;
      end else if (hp_pend) begin
        load      = 1'b1;
        take_hp   = 1'b1;
        load_type = TYPE_HP;
        load_pay  = 16'(hp_local);
      end else if (hb_pend) begin
        load      = 1'b1;
        load_type = TYPE_HB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outside IDLE tx_valid is always high, so tx_ready alone marks a transfer.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (load)     state_next = ST_SYNC;
      ST_SYNC: if (tx_ready) state_next = ST_TYPE;
      ST_TYPE: if (tx_ready) state_next = ST_PHI;
      ST_PHI:  if (tx_ready) state_next = ST_PLO;
`ifdef GAME_LINK_CHECKSUM_EN
      ST_PLO:  if (tx_ready) state_next = ST_CHK;
      ST_CHK:  if (tx_ready) state_next = ST_IDLE;
`else
      ST_PLO:  if (tx_ready) state_next = ST_IDLE;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = 1'b1;
    busy      = 1'b1;
    tx_data   = 8'h00;
    last_byte = 1'b0;
    case (state)
      ST_SYNC: tx_data = SYNC_BYTE;
      ST_TYPE: tx_data = type_q;
      ST_PHI:  tx_data = pay_q[15:8];
      ST_PLO: begin
        tx_data = pay_q[7:0];
`ifndef GAME_LINK_CHECKSUM_EN
        last_byte = 1'b1;
`endif
      end
`ifdef GAME_LINK_CHECKSUM_EN
      ST_CHK: begin
        tx_data   = pkt_chk(type_q, pay_q);
        last_byte = 1'b1;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // A pulse arriving in the same cycle its flag is consumed re-arms the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_pend <= 1'b0;
      turn_pend  <= 1'b0;
      hp_shadow  <= '0;
      type_q     <= '0;
      pay_q      <= '0;
      pkt_sent   <= 1'b0;
    end else begin
      enter_pend <= enter_pressed_local | (enter_pend & ~take_enter);
      turn_pend  <= turn_done_local | (turn_pend & ~take_turn);
      if (take_hp) begin
        hp_shadow <= hp_local;
      end
      if (load) begin
        type_q <= load_type;
        pay_q  <= load_pay;
      end
      pkt_sent <= last_byte & tx_ready;
    end
  end

endmodule
